// File: rtl/lsu_pkg.sv
// Shared encodings and lane/extract helpers for the load/store memory adapter.
// Everything here assumes a 32-bit data path with four byte lanes.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] d;
    logic [31:0] r;
    d = rdata >> {off, 3'b000};
    case (size)
      SZ_B:    r = {{24{~uns & d[7]}}, d[7:0]};
      SZ_H:    r = {{16{~uns & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_adapter_align.sv
// Combinational lane logic: byte mask, write-data shift, load extension and
// the alignment check for one access.
module lsu_mem_adapter_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_shifted,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  always_comb begin
    mask          = lane_mask(off, size);
    wdata_shifted = wdata << {off, 3'b000};
    rdata_ext     = load_extract(rdata, off, size, uns);
    misaligned    = is_misaligned(off, size);
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter in front of the data RAM: latches one request, holds the
// RAM access for LATENCY cycles and returns an extended result or an error.
//
// state  | meaning
// IDLE   | ready for a request; misaligned requests go straight to RESP
// ACCESS | RAM access held; counter counts down to the sampling cycle
// RESP   | registered response presented until resp_ready
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int XLEN    = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_valid,
  output logic            mem_write_enable,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_write_data,
  output logic [3:0]      mem_write_mask,
  input  logic [XLEN-1:0] mem_read_data
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  lsu_state_e      state, state_nxt;
  logic [CW-1:0]   counter, counter_nxt;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            wen_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            take_req;
  logic            capture;
  logic [1:0]      sel_off;
  logic [1:0]      sel_size;
  logic [3:0]      lane_mask_w;
  logic [31:0]     wdata_sh;
  logic [31:0]     rdata_ext;
  logic            misaligned;

  // In IDLE the aligner judges the incoming request; afterwards it works on the latched one.
  assign sel_off  = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];
  assign sel_size = (state == IDLE) ? req_size      : size_q;

  lsu_mem_adapter_align u_align (
    .off           (sel_off),
    .size          (sel_size),
    .uns           (uns_q),
    .wdata         (wdata_q),
    .rdata         (mem_read_data),
    .mask          (lane_mask_w),
    .wdata_shifted (wdata_sh),
    .rdata_ext     (rdata_ext),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      if (take_req) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wen_q   <= req_wen;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        rdata_q <= '0;
        err_q   <= misaligned;
      end
      if (capture) begin
        rdata_q <= wen_q ? '0 : rdata_ext;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    counter_nxt      = counter;
    take_req         = 1'b0;
    capture          = 1'b0;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_valid        = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_write_data   = '0;
    mem_write_mask   = 4'b0000;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          take_req = 1'b1;
          if (misaligned) begin
            state_nxt = RESP;
          end else begin
            state_nxt   = ACCESS;
            counter_nxt = CW'(LATENCY - 1);
          end
        end
      end
      ACCESS: begin
        mem_valid      = 1'b1;
        mem_addr       = {addr_q[XLEN-1:2], 2'b00};
        mem_write_data = wdata_sh;
        mem_write_mask = lane_mask_w;
        if (counter == '0) begin
          // Final cycle: strobe the write once, or sample read data at the closing edge.
          mem_write_enable = wen_q;
          capture          = 1'b1;
          state_nxt        = RESP;
        end else begin
          counter_nxt = counter - CW'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Bench for lsu_mem_adapter: two instances (LATENCY 1 and 3) driven with
// directed and random requests, checked against an arithmetic reference model.
module tb_lsu_mem_adapter;

  logic        clock;
  logic        reset          [2];
  logic        req_valid      [2];
  logic        req_ready      [2];
  logic [31:0] req_addr       [2];
  logic        req_wen        [2];
  logic [31:0] req_wdata      [2];
  logic [1:0]  req_size       [2];
  logic        req_unsigned   [2];
  logic        resp_valid     [2];
  logic        resp_ready     [2];
  logic [31:0] resp_rdata     [2];
  logic        resp_err       [2];
  logic        mem_valid      [2];
  logic        mem_write_enable [2];
  logic [31:0] mem_addr       [2];
  logic [31:0] mem_write_data [2];
  logic [3:0]  mem_write_mask [2];
  logic [31:0] mem_read_data  [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lsu_mem_adapter #(.LATENCY((g == 0) ? 1 : 3), .XLEN(32)) u_dut (
      .clock            (clock),
      .reset            (reset[g]),
      .req_valid        (req_valid[g]),
      .req_ready        (req_ready[g]),
      .req_addr         (req_addr[g]),
      .req_wen          (req_wen[g]),
      .req_wdata        (req_wdata[g]),
      .req_size         (req_size[g]),
      .req_unsigned     (req_unsigned[g]),
      .resp_valid       (resp_valid[g]),
      .resp_ready       (resp_ready[g]),
      .resp_rdata       (resp_rdata[g]),
      .resp_err         (resp_err[g]),
      .mem_valid        (mem_valid[g]),
      .mem_write_enable (mem_write_enable[g]),
      .mem_addr         (mem_addr[g]),
      .mem_write_data   (mem_write_data[g]),
      .mem_write_mask   (mem_write_mask[g]),
      .mem_read_data    (mem_read_data[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: a request covers 2**size bytes starting at byte offset addr%4.
  function automatic void model(input logic [31:0] addr, input logic wen,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic uns, input logic [31:0] rd,
                                output logic err, output logic [31:0] rdata,
                                output logic [3:0] mask, output logic [31:0] wsh);
    int nbytes = 1 << size;
    int off = int'(addr[1:0]);
    longint unsigned d;
    longint unsigned lim;
    longint unsigned v;
    err  = (size == 2'd3) || ((off % nbytes) != 0);
    mask = 4'(((1 << nbytes) - 1) << off);
    wsh  = 32'(64'(wdata) << (8 * off));
    d    = 64'(rd) >> (8 * off);
    lim  = (64'd1 << (8 * nbytes)) - 64'd1;
    v    = d & lim;
    if (!uns && ((v >> (8 * nbytes - 1)) & 64'd1) != 64'd0) v = v | ~lim;
    rdata = (err || wen) ? 32'd0 : 32'(v);
  endfunction

  // Issues one request from an idle adapter and follows it through to the handshake.
  task automatic run_txn(input int d, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input logic [31:0] rd, input int hold, input string tag);
    logic        e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_mask;
    logic [31:0] e_wsh;
    logic        e_we;
    int          lat;
    lat = lat_of(d);
    model(addr, wen, wdata, size, uns, rd, e_err, e_rdata, e_mask, e_wsh);
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: req_ready=%b want 1", tag, req_ready[d]);
    end
    req_addr[d] = addr; req_wen[d] = wen; req_wdata[d] = wdata;
    req_size[d] = size; req_unsigned[d] = uns; mem_read_data[d] = rd;
    resp_ready[d] = 1'b0; req_valid[d] = 1'b1;
    @(negedge clock);
    req_valid[d] = 1'b1;
    req_addr[d] = $urandom; req_wen[d] = 1'($urandom); req_wdata[d] = $urandom;
    req_size[d] = 2'($urandom); req_unsigned[d] = 1'($urandom);
    if (!e_err) begin
      for (int k = 0; k < lat; k++) begin
        e_we = wen && (k == lat - 1);
        checks++;
        if (mem_valid[d] !== 1'b1 || mem_addr[d] !== {addr[31:2], 2'b00} ||
            mem_write_mask[d] !== e_mask || mem_write_data[d] !== e_wsh) begin
          errors++;
          $display("FAIL %s access[%0d]: valid=%b addr=%h mask=%b wdata=%h want 1 %h %b %h",
                   tag, k, mem_valid[d], mem_addr[d], mem_write_mask[d], mem_write_data[d],
                   {addr[31:2], 2'b00}, e_mask, e_wsh);
        end
        checks++;
        if (mem_write_enable[d] !== e_we) begin
          errors++;
          $display("FAIL %s write_enable[%0d]: got %b want %b", tag, k, mem_write_enable[d], e_we);
        end
        checks++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s busy[%0d]: resp_valid=%b req_ready=%b want 0 0",
                   tag, k, resp_valid[d], req_ready[d]);
        end
        @(negedge clock);
      end
    end
    req_valid[d] = 1'b0;
    checks++;
    if (mem_valid[d] !== 1'b0 || mem_write_enable[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s mem_idle_in_resp: mem_valid=%b we=%b want 0 0",
               tag, mem_valid[d], mem_write_enable[d]);
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== e_rdata || resp_err[d] !== e_err ||
          req_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s resp[%0d]: valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                 tag, h, resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d], e_rdata, e_err);
      end
      if (h < hold) begin
        mem_read_data[d] = $urandom;
        @(negedge clock);
      end
    end
    resp_ready[d] = 1'b1;
    @(negedge clock);
    resp_ready[d] = 1'b0;
    checks++;
    if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake: resp_valid=%b req_ready=%b want 0 1",
               tag, resp_valid[d], req_ready[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b0; req_valid[d] = 1'b0; req_addr[d] = '0; req_wen[d] = 1'b0;
      req_wdata[d] = '0; req_size[d] = '0; req_unsigned[d] = 1'b0;
      resp_ready[d] = 1'b0; mem_read_data[d] = '0;
    end
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b1;
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'd0 ||
          resp_err[d] !== 1'b0 || mem_valid[d] !== 1'b0 || mem_write_enable[d] !== 1'b0 ||
          mem_addr[d] !== 32'd0 || mem_write_data[d] !== 32'd0 || mem_write_mask[d] !== 4'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: ready=%b rv=%b rd=%h err=%b mv=%b we=%b ma=%h md=%h mm=%b",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d], mem_valid[d],
                 mem_write_enable[d], mem_addr[d], mem_write_data[d], mem_write_mask[d]);
      end
    end
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mem_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_held[%0d]: mem_valid=%b req_ready=%b want 0 1", d, mem_valid[d], req_ready[d]);
      end
      req_valid[d] = 1'b0;
      reset[d] = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic test_store_byte();
    run_txn(0, 32'h8000_0003, 1'b1, 32'h0000_00AB, 2'd0, 1'b0, 32'h1234_5678, 0, "store_byte_l1");
    run_txn(1, 32'h8000_0003, 1'b1, 32'h0000_00AB, 2'd0, 1'b0, 32'h1234_5678, 1, "store_byte_l3");
  endtask

  task automatic test_half_load();
    run_txn(0, 32'h8000_0002, 1'b0, 32'h0, 2'd1, 1'b0, 32'h8001_FFFE, 0, "half_signed");
    run_txn(0, 32'h8000_0002, 1'b0, 32'h0, 2'd1, 1'b1, 32'h8001_FFFE, 0, "half_unsigned");
    run_txn(1, 32'h8000_0001, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0000_F000, 0, "byte_signed_off1");
  endtask

  task automatic test_misaligned();
    run_txn(0, 32'h8000_0002, 1'b0, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1, "misaligned_word");
    run_txn(1, 32'h8000_0001, 1'b1, 32'h55, 2'd1, 1'b0, 32'hDEAD_BEEF, 0, "misaligned_half");
  endtask

  task automatic test_word_load_stall();
    run_txn(1, 32'h8000_0010, 1'b0, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 5, "word_load_stall");
  endtask

  task automatic test_illegal_size();
    for (int i = 0; i < 4; i++)
      run_txn(i % 2, $urandom, 1'($urandom), $urandom, 2'd3, 1'($urandom), $urandom,
              int'($urandom_range(0, 2)), "illegal_size");
  endtask

  task automatic test_async_reset();
    req_addr[1] = 32'h8000_0040; req_wen[1] = 1'b1; req_wdata[1] = 32'h1357_9BDF;
    req_size[1] = 2'd2; req_unsigned[1] = 1'b0; resp_ready[1] = 1'b1; req_valid[1] = 1'b1;
    @(negedge clock);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (mem_valid[1] !== 1'b1 || mem_write_enable[1] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_pre: mem_valid=%b we=%b want 1 1", mem_valid[1], mem_write_enable[1]);
    end
    #2 reset[1] = 1'b0;
    #1;
    checks++;
    if (mem_valid[1] !== 1'b0 || mem_write_enable[1] !== 1'b0 || resp_valid[1] !== 1'b0 ||
        req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_drop: mv=%b we=%b rv=%b ready=%b want 0 0 0 1",
               mem_valid[1], mem_write_enable[1], resp_valid[1], req_ready[1]);
    end
    @(negedge clock);
    reset[1] = 1'b1;
    repeat (2) begin
      @(negedge clock);
      checks++;
      if (resp_valid[1] !== 1'b0 || mem_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
        errors++;
        $display("FAIL async_reset_no_resp: rv=%b mv=%b ready=%b want 0 0 1",
                 resp_valid[1], mem_valid[1], req_ready[1]);
      end
    end
    resp_ready[1] = 1'b0;
    run_txn(1, 32'h8000_0042, 1'b0, 32'h0, 2'd1, 1'b1, 32'h9876_5432, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [1:0] sz;
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 3));
      run_txn(i % 2, $urandom, 1'($urandom), $urandom, sz, 1'($urandom), $urandom,
              int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_back_to_back(input int d);
    int          acc_cyc[$];
    logic [31:0] exp_rd[$];
    logic        exp_er[$];
    logic        e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_mask;
    logic [31:0] e_wsh;
    logic [1:0]  sz;
    logic        accepted_last;
    int          lat;
    lat = lat_of(d);
    mem_read_data[d] = $urandom;
    resp_ready[d] = 1'b1;
    accepted_last = 1'b1;
    for (int cyc = 0; cyc < 200 && acc_cyc.size() < 6; cyc++) begin
      if (accepted_last) begin
        sz = 2'($urandom_range(0, 2));
        req_addr[d] = $urandom & ~((32'd1 << sz) - 32'd1);
        req_size[d] = sz; req_wen[d] = 1'($urandom);
        req_wdata[d] = $urandom; req_unsigned[d] = 1'($urandom);
        req_valid[d] = 1'b1;
      end
      accepted_last = 1'b0;
      if (resp_valid[d] === 1'b1) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_resp[%0d]: resp_valid=1 with nothing outstanding", d);
        end else begin
          if (resp_rdata[d] !== exp_rd[0] || resp_err[d] !== exp_er[0]) begin
            errors++;
            $display("FAIL b2b_resp[%0d]: rdata=%h err=%b want %h %b",
                     d, resp_rdata[d], resp_err[d], exp_rd[0], exp_er[0]);
          end
          void'(exp_rd.pop_front());
          void'(exp_er.pop_front());
        end
      end
      if (req_ready[d] === 1'b1) begin
        model(req_addr[d], req_wen[d], req_wdata[d], req_size[d], req_unsigned[d],
              mem_read_data[d], e_err, e_rdata, e_mask, e_wsh);
        exp_rd.push_back(e_rdata);
        exp_er.push_back(e_err);
        acc_cyc.push_back(cyc);
        accepted_last = 1'b1;
      end
      @(negedge clock);
    end
    req_valid[d] = 1'b0;
    checks++;
    if (acc_cyc.size() < 6) begin
      errors++;
      $display("FAIL b2b_timeout[%0d]: accepts=%0d want 6", d, acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != lat + 2) begin
        errors++;
        $display("FAIL b2b_interval[%0d]: got %0d want %0d", d, acc_cyc[i] - acc_cyc[i-1], lat + 2);
      end
    end
    for (int w = 0; w < 20 && exp_rd.size() > 0; w++) begin
      if (resp_valid[d] === 1'b1) begin
        checks++;
        if (resp_rdata[d] !== exp_rd[0] || resp_err[d] !== exp_er[0]) begin
          errors++;
          $display("FAIL b2b_drain[%0d]: rdata=%h err=%b want %h %b",
                   d, resp_rdata[d], resp_err[d], exp_rd[0], exp_er[0]);
        end
        void'(exp_rd.pop_front());
        void'(exp_er.pop_front());
      end
      @(negedge clock);
    end
    checks++;
    if (exp_rd.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing_resp[%0d]: outstanding=%0d want 0", d, exp_rd.size());
    end
    resp_ready[d] = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_half_load();
    test_misaligned();
    test_word_load_stall();
    test_illegal_size();
    test_async_reset();
    test_random();
    test_back_to_back(0);
    test_back_to_back(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
